// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants and
// the baud divider rounding helper. Also intended for the future uart_tx.
package uart_rx_pkg;

  // Oversampling ratio and the mid-bit sample tick within one bit time
  localparam int OSR       = 16;
  localparam int SAMPLE_PT = 7;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Rounded clock divider for one oversample tick, never below 1
  function automatic int div_calc(input longint clk_hz, input longint baud);
    longint den;
    longint q;
    den = baud * longint'(OSR);
    q   = (clk_hz + (den / 64'sd2)) / den;
    if (q < 64'sd1) begin
      q = 64'sd1;
    end else begin
      q = q;
    end
    return int'(q);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: div_cnt runs 0..DIV-1 and flags a tick on the
// last count. A synchronous clear realigns the phase to a start edge.
module uart_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  output logic tick
);

  localparam int DIV   = div_calc(longint'(CLK_HZ), longint'(BAUD));
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;

  assign tick_s = (div_cnt_r == DIV_W'(DIV - 1));
  assign tick   = tick_s;

  // Divider counter: cleared by reset, by a start edge and after each tick
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      div_cnt_r <= '0;
    end else if (clr) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled with a mid-bit sample. Received bytes
// land in a one-entry valid/ready register; framing and overrun errors are
// reported as single-cycle pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  logic                 rx_meta_r;
  logic                 rxs_r;
  uart_state_e          state_r;
  uart_state_e          state_s;
  logic [3:0]           osr_cnt_r;
  logic [3:0]           osr_cnt_s;
  logic [3:0]           bit_cnt_r;
  logic [3:0]           bit_cnt_s;
  logic [3:0]           hunt_cnt_r;
  logic [3:0]           hunt_cnt_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 tick_s;
  logic                 clr_s;
  logic                 good_s;
  logic                 ferr_s;
  logic                 busy_s;
  logic [DATA_BITS-1:0] m_tdata_r;
  logic                 m_tvalid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_baud_tick (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (clr_s),
    .tick    (tick_s)
  );

  // Two-flop synchronizer for the asynchronous line, idle-high reset value
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rxd;
      rxs_r     <= rx_meta_r;
    end
  end

  // FSM state and per-frame counters
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r    <= ST_HUNT;
      osr_cnt_r  <= 4'd0;
      bit_cnt_r  <= 4'd0;
      hunt_cnt_r <= 4'd0;
      shift_r    <= '0;
    end else begin
      state_r    <= state_s;
      osr_cnt_r  <= osr_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      hunt_cnt_r <= hunt_cnt_s;
      shift_r    <= shift_s;
    end
  end

  // Next-state logic: hunting for idle line, start qualification, bit sampling
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    hunt_cnt_s = hunt_cnt_r;
    shift_s    = shift_r;
    clr_s      = 1'b0;
    good_s     = 1'b0;
    ferr_s     = 1'b0;
    if (tick_s) begin
      osr_cnt_s = osr_cnt_r + 4'd1;
    end else begin
      osr_cnt_s = osr_cnt_r;
    end

    case (state_r)
      ST_HUNT: begin
        // Any low sample restarts the 16-tick idle qualification
        if (!rxs_r) begin
          hunt_cnt_s = 4'd0;
        end else if (tick_s) begin
          if (hunt_cnt_r == 4'(OSR - 1)) begin
            hunt_cnt_s = 4'd0;
            state_s    = ST_IDLE;
          end else begin
            hunt_cnt_s = hunt_cnt_r + 4'd1;
          end
        end else begin
          hunt_cnt_s = hunt_cnt_r;
        end
      end
      ST_IDLE: begin
        if (!rxs_r) begin
          clr_s     = 1'b1;
          osr_cnt_s = 4'd0;
          bit_cnt_s = 4'd0;
          state_s   = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && (osr_cnt_r == 4'(SAMPLE_PT))) begin
          if (rxs_r) begin
            state_s = ST_IDLE;
          end else begin
            osr_cnt_s = 4'd0;
            state_s   = ST_DATA;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (osr_cnt_r == 4'(OSR - 1))) begin
          shift_s = {rxs_r, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
            bit_cnt_s = 4'd0;
            state_s   = ST_STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s && (osr_cnt_r == 4'(OSR - 1))) begin
          if (rxs_r) begin
            good_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_s     = 1'b1;
            hunt_cnt_s = 4'd0;
            state_s    = ST_HUNT;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        hunt_cnt_s = 4'd0;
        state_s    = ST_HUNT;
      end
    endcase

    // A disabled receiver always falls back to hunting for an idle line
    if (!en) begin
      state_s    = ST_HUNT;
      hunt_cnt_s = 4'd0;
    end else begin
      state_s = state_s;
    end
  end

  assign busy_s = (state_s == ST_START) || (state_s == ST_DATA) || (state_s == ST_STOP);

  // Output register: one-entry buffer with overrun detection and status pulses
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_tdata_r   <= '0;
      m_tvalid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      busy_r      <= busy_s;
      if (good_s) begin
        // Free slot, or the held byte leaves in this same cycle
        if (!m_tvalid_r || m_tready) begin
          m_tdata_r  <= shift_r;
          m_tvalid_r <= 1'b1;
          overrun_r  <= 1'b0;
        end else begin
          overrun_r <= 1'b1;
        end
      end else begin
        overrun_r <= 1'b0;
        if (m_tvalid_r && m_tready) begin
          m_tvalid_r <= 1'b0;
        end else begin
          m_tvalid_r <= m_tvalid_r;
        end
      end
    end
  end

  assign m_tdata   = m_tdata_r;
  assign m_tvalid  = m_tvalid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=4 (one bit = 64 clocks).
module tb_uart_rx;

  localparam int CLK_HZ    = 6_400_000;
  localparam int BAUD      = 100_000;
  localparam int DATA_BITS = 8;
  localparam int BIT_CYC   = 64;

  logic       aclk     = 1'b0;
  logic       aresetn  = 1'b0;
  logic       en       = 1'b1;
  logic       rxd      = 1'b1;
  logic       m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  uart_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .en        (en),
    .rxd       (rxd),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Observed traffic, sampled on the falling edge
  logic [7:0] rx_q[$];
  int   ovr_cnt   = 0;
  int   ferr_cnt  = 0;
  int   rise_cnt  = 0;
  int   rise_cyc  = 0;
  logic prev_valid = 1'b0;

  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) rx_q.push_back(m_tdata);
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (m_tvalid && !prev_valid) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    prev_valid <= m_tvalid;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_v);
    rxd = 1'b0;
    wait_cyc(bc);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(bc);
    end
    rxd = stop_v;
    wait_cyc(bc);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    rxd = 1'b1; m_tready = 1'b0; aresetn = 1'b0;
    wait_cyc(4);
    chk_cnt++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%0b exp=0", m_tvalid); else pass_cnt++;
    chk_cnt++; if (m_tdata !== 8'h00) $display("FAIL reset_tdata got=%02h exp=00", m_tdata); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%0b exp=0", frame_err); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%0b exp=0", overrun); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
    aresetn = 1'b1;
    wait_cyc(100);
  endtask

  task automatic test_single();
    int base, r0, c0, lat;
    m_tready = 1'b1;
    base = rx_q.size(); r0 = rise_cnt; c0 = cyc;
    send_byte(8'h55, BIT_CYC, 1'b1);
    wait_cyc(4);
    lat = rise_cyc - c0;
    chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL single_count got=%0d exp=1", rx_q.size() - base); else pass_cnt++;
    chk_cnt++; if (rx_q[base] !== 8'h55) $display("FAIL single_data got=%02h exp=55", rx_q[base]); else pass_cnt++;
    chk_cnt++; if (rise_cnt - r0 !== 1) $display("FAIL single_rises got=%0d exp=1", rise_cnt - r0); else pass_cnt++;
    chk_cnt++; if (lat < 610 || lat > 612) $display("FAIL single_latency got=%0d exp=611+/-1", lat); else pass_cnt++;
    chk_cnt++; if (m_tvalid !== 1'b0) $display("FAIL single_tvalid_clear got=%0b exp=0", m_tvalid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int base, o0;
    m_tready = 1'b0;
    base = rx_q.size(); o0 = ovr_cnt;
    send_byte(8'hA3, BIT_CYC, 1'b1);
    send_byte(8'h0F, BIT_CYC, 1'b1);
    wait_cyc(4);
    chk_cnt++; if (m_tvalid !== 1'b1) $display("FAIL b2b_held_valid got=%0b exp=1", m_tvalid); else pass_cnt++;
    chk_cnt++; if (m_tdata !== 8'hA3) $display("FAIL b2b_held_data got=%02h exp=a3", m_tdata); else pass_cnt++;
    chk_cnt++; if (ovr_cnt - o0 !== 1) $display("FAIL b2b_overrun got=%0d exp=1", ovr_cnt - o0); else pass_cnt++;
    m_tready = 1'b1;
    wait_cyc(3);
    chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL b2b_count got=%0d exp=1", rx_q.size() - base); else pass_cnt++;
    chk_cnt++; if (rx_q[base] !== 8'hA3) $display("FAIL b2b_data got=%02h exp=a3", rx_q[base]); else pass_cnt++;
    chk_cnt++; if (m_tvalid !== 1'b0) $display("FAIL b2b_drained got=%0b exp=0", m_tvalid); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int base, f0, r0, o0;
    m_tready = 1'b1;
    base = rx_q.size(); f0 = ferr_cnt; r0 = rise_cnt; o0 = ovr_cnt;
    send_byte(8'hC4, BIT_CYC, 1'b0);
    wait_cyc(16 * BIT_CYC);
    chk_cnt++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); else pass_cnt++;
    chk_cnt++; if (rise_cnt - r0 !== 0) $display("FAIL ferr_no_valid got=%0d exp=0", rise_cnt - r0); else pass_cnt++;
    chk_cnt++; if (ovr_cnt - o0 !== 0) $display("FAIL ferr_no_overrun got=%0d exp=0", ovr_cnt - o0); else pass_cnt++;
    send_byte(8'h3C, BIT_CYC, 1'b1);
    wait_cyc(4);
    chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL ferr_next_count got=%0d exp=1", rx_q.size() - base); else pass_cnt++;
    chk_cnt++; if (rx_q[base] !== 8'h3C) $display("FAIL ferr_next_data got=%02h exp=3c", rx_q[base]); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int base, f0, r0;
    m_tready = 1'b1;
    base = rx_q.size(); f0 = ferr_cnt; r0 = rise_cnt;
    rxd = 1'b0;
    wait_cyc(20);
    rxd = 1'b1;
    wait_cyc(200);
    chk_cnt++; if (rise_cnt - r0 !== 0) $display("FAIL glitch_no_valid got=%0d exp=0", rise_cnt - r0); else pass_cnt++;
    chk_cnt++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_no_ferr got=%0d exp=0", ferr_cnt - f0); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy got=%0b exp=0", busy); else pass_cnt++;
    send_byte(8'h81, BIT_CYC, 1'b1);
    wait_cyc(4);
    chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL glitch_next_count got=%0d exp=1", rx_q.size() - base); else pass_cnt++;
    chk_cnt++; if (rx_q[base] !== 8'h81) $display("FAIL glitch_next_data got=%02h exp=81", rx_q[base]); else pass_cnt++;
  endtask

  task automatic test_hunt();
    int base, r0, f0;
    m_tready = 1'b1;
    aresetn = 1'b0; rxd = 1'b0;
    wait_cyc(4);
    aresetn = 1'b1;
    r0 = rise_cnt; f0 = ferr_cnt;
    wait_cyc(200);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL hunt_low_busy got=%0b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (rise_cnt - r0 !== 0) $display("FAIL hunt_low_valid got=%0d exp=0", rise_cnt - r0); else pass_cnt++;
    chk_cnt++; if (ferr_cnt - f0 !== 0) $display("FAIL hunt_low_ferr got=%0d exp=0", ferr_cnt - f0); else pass_cnt++;
    rxd = 1'b1;
    wait_cyc(100);
    base = rx_q.size();
    send_byte(8'h7E, BIT_CYC, 1'b1);
    wait_cyc(4);
    chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL hunt_count got=%0d exp=1", rx_q.size() - base); else pass_cnt++;
    chk_cnt++; if (rx_q[base] !== 8'h7E) $display("FAIL hunt_data got=%02h exp=7e", rx_q[base]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int base;
    b = 8'hA5;
    rxd = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      wait_cyc(BIT_CYC);
    end
    rxd = b[3];
    wait_cyc(BIT_CYC / 2);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got=%0b exp=1", busy); else pass_cnt++;
    aresetn = 1'b0;
    wait_cyc(1);
    chk_cnt++; if (m_tvalid !== 1'b0) $display("FAIL midrst_tvalid got=%0b exp=0", m_tvalid); else pass_cnt++;
    chk_cnt++; if (m_tdata !== 8'h00) $display("FAIL midrst_tdata got=%02h exp=00", m_tdata); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%0b exp=0", busy); else pass_cnt++;
    chk_cnt++; if ((frame_err | overrun) !== 1'b0) $display("FAIL midrst_flags got=%0b exp=0", frame_err | overrun); else pass_cnt++;
    aresetn = 1'b1;
    rxd = 1'b1;
    wait_cyc(200);
    base = rx_q.size();
    send_byte(8'h5A, BIT_CYC, 1'b1);
    wait_cyc(4);
    chk_cnt++; if (rx_q.size() - base !== 1) $display("FAIL midrst_next_count got=%0d exp=1", rx_q.size() - base); else pass_cnt++;
    chk_cnt++; if (rx_q[base] !== 8'h5A) $display("FAIL midrst_next_data got=%02h exp=5a", rx_q[base]); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic [7:0] b;
    int base, o0;
    m_tready = 1'b0;
    base = rx_q.size(); o0 = ovr_cnt;
    send_byte(8'h11, BIT_CYC, 1'b1);
    wait_cyc(10);
    chk_cnt++; if (m_tdata !== 8'h11 || m_tvalid !== 1'b1) $display("FAIL same_first got=%02h/%0b exp=11/1", m_tdata, m_tvalid); else pass_cnt++;
    b = 8'h12;
    rxd = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(BIT_CYC);
    end
    rxd = 1'b1;
    // Stop sample lands 611 clocks after the start edge; accept the old byte in that cycle
    wait_cyc(34);
    m_tready = 1'b1;
    wait_cyc(1);
    chk_cnt++; if (m_tdata !== 8'h12) $display("FAIL same_data got=%02h exp=12", m_tdata); else pass_cnt++;
    chk_cnt++; if (m_tvalid !== 1'b1) $display("FAIL same_valid got=%0b exp=1", m_tvalid); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL same_overrun got=%0b exp=0", overrun); else pass_cnt++;
    wait_cyc(29 + 4);
    chk_cnt++; if (ovr_cnt - o0 !== 0) $display("FAIL same_overrun_cnt got=%0d exp=0", ovr_cnt - o0); else pass_cnt++;
    chk_cnt++; if (rx_q.size() - base !== 2) $display("FAIL same_count got=%0d exp=2", rx_q.size() - base); else pass_cnt++;
    chk_cnt++; if (rx_q[base + 1] !== 8'h12) $display("FAIL same_second got=%02h exp=12", rx_q[base + 1]); else pass_cnt++;
  endtask

  task automatic test_skew();
    int base, f0;
    m_tready = 1'b1;
    base = rx_q.size(); f0 = ferr_cnt;
    send_byte(8'hFF, 66, 1'b1);
    wait_cyc(50);
    send_byte(8'h00, 62, 1'b1);
    wait_cyc(10);
    chk_cnt++; if (rx_q.size() - base !== 2) $display("FAIL skew_count got=%0d exp=2", rx_q.size() - base); else pass_cnt++;
    chk_cnt++; if (rx_q[base] !== 8'hFF) $display("FAIL skew_slow got=%02h exp=ff", rx_q[base]); else pass_cnt++;
    chk_cnt++; if (rx_q[base + 1] !== 8'h00) $display("FAIL skew_fast got=%02h exp=00", rx_q[base + 1]); else pass_cnt++;
    chk_cnt++; if (ferr_cnt - f0 !== 0) $display("FAIL skew_ferr got=%0d exp=0", ferr_cnt - f0); else pass_cnt++;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_hunt();
    test_reset_mid_frame();
    test_same_cycle();
    test_skew();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
